// File: rtl/qpu_exu_alu_lsu_agu_pkg.sv
// Shared widths, FSM encoding and captured-op payload for the QPU LSU sequencer.
package qpu_exu_alu_lsu_agu_pkg;

    localparam int unsigned QPU_XLEN    = 32;
    localparam int unsigned QPU_RDIDX_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_CMD  = 3'd2,
        ST_RSP  = 3'd3,
        ST_WB   = 3'd4
    } lsu_state_e;

    // One dispatched load/store as held for the whole transaction.
    typedef struct packed {
        logic                   load;
        logic [QPU_XLEN-1:0]    rs1;
        logic [QPU_XLEN-1:0]    imm;
        logic [QPU_XLEN-1:0]    wdata;
        logic [QPU_RDIDX_W-1:0] rdidx;
    } lsu_op_t;

endpackage

// File: rtl/qpu_exu_alu_lsu_agu.sv
// Single-outstanding load/store sequencer: borrows the ALU adder for the
// effective address, then runs one memory cmd/rsp and a write-back handshake.
// Optional alignment check: QPU_LSU_MISALIGN_CHK_EN.
module qpu_exu_alu_lsu_agu
    import qpu_exu_alu_lsu_agu_pkg::*;
#(
    parameter int unsigned XLEN    = QPU_XLEN,
    parameter int unsigned RDIDX_W = QPU_RDIDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic               i_load,
    input  logic [XLEN-1:0]    i_rs1,
    input  logic [XLEN-1:0]    i_imm,
    input  logic [XLEN-1:0]    i_wdata,
    input  logic [RDIDX_W-1:0] i_rdidx,
    output logic               lsu_req_alu,
    output logic [XLEN-1:0]    lsu_req_alu_op1,
    output logic [XLEN-1:0]    lsu_req_alu_op2,
    input  logic [XLEN-1:0]    lsu_req_alu_res,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic               cmd_read,
    output logic [XLEN-1:0]    cmd_addr,
    output logic [XLEN-1:0]    cmd_wdata,
    input  logic               rsp_valid,
    output logic               rsp_ready,
    input  logic [XLEN-1:0]    rsp_rdata,
    input  logic               rsp_err,
    output logic               wbck_valid,
    input  logic               wbck_ready,
    output logic [XLEN-1:0]    wbck_wdat,
    output logic [RDIDX_W-1:0] wbck_rdidx,
    output logic               wbck_err,
    output logic               busy
);

    lsu_state_e         state_q, state_d;
    lsu_op_t            op_q, op_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               i_ready_q, i_ready_d;
    logic               busy_q, busy_d;
    logic               lsu_req_alu_q, lsu_req_alu_d;
    logic [XLEN-1:0]    lsu_req_alu_op1_q, lsu_req_alu_op1_d;
    logic [XLEN-1:0]    lsu_req_alu_op2_q, lsu_req_alu_op2_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               cmd_read_q, cmd_read_d;
    logic [XLEN-1:0]    cmd_addr_q, cmd_addr_d;
    logic [XLEN-1:0]    cmd_wdata_q, cmd_wdata_d;
    logic               rsp_ready_q, rsp_ready_d;
    logic               wbck_valid_q, wbck_valid_d;
    logic [XLEN-1:0]    wbck_wdat_q, wbck_wdat_d;
    logic [RDIDX_W-1:0] wbck_rdidx_q, wbck_rdidx_d;
    logic               wbck_err_q, wbck_err_d;

    // Next state, capture registers, and outputs decoded from the next state
    // so every port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_valid && i_ready_q) begin
                    op_d.load  = i_load;
                    op_d.rs1   = i_rs1;
                    op_d.imm   = i_imm;
                    op_d.wdata = i_wdata;
                    op_d.rdidx = i_rdidx;
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                addr_d = lsu_req_alu_res;
`ifdef QPU_LSU_MISALIGN_CHK_EN
                if (lsu_req_alu_res[1:0] != 2'b00) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_WB;
                end else begin
                    state_d = ST_CMD;
                end
`else
                state_d = ST_CMD;
`endif
            end
            ST_CMD: begin
                if (cmd_valid_q && cmd_ready) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_valid) begin
                    rdata_d = op_q.load ? rsp_rdata : '0;
                    err_d   = rsp_err;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (wbck_valid_q && wbck_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        i_ready_d         = (state_d == ST_IDLE);
        busy_d            = (state_d != ST_IDLE);
        lsu_req_alu_d     = (state_d == ST_ADDR);
        lsu_req_alu_op1_d = (state_d == ST_ADDR) ? op_d.rs1 : '0;
        lsu_req_alu_op2_d = (state_d == ST_ADDR) ? op_d.imm : '0;
        cmd_valid_d       = (state_d == ST_CMD);
        cmd_read_d        = (state_d == ST_CMD) && op_d.load;
        cmd_addr_d        = (state_d == ST_CMD) ? addr_d : '0;
        cmd_wdata_d       = ((state_d == ST_CMD) && !op_d.load) ? op_d.wdata : '0;
        rsp_ready_d       = (state_d == ST_RSP);
        wbck_valid_d      = (state_d == ST_WB);
        wbck_wdat_d       = (state_d == ST_WB) ? rdata_d : '0;
        wbck_rdidx_d      = ((state_d == ST_WB) && op_d.load) ? op_d.rdidx : '0;
        wbck_err_d        = (state_d == ST_WB) && err_d;
    end

    // State register; async reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            op_q              <= '0;
            addr_q            <= '0;
            rdata_q           <= '0;
            err_q             <= 1'b0;
            i_ready_q         <= 1'b0;
            busy_q            <= 1'b0;
            lsu_req_alu_q     <= 1'b0;
            lsu_req_alu_op1_q <= '0;
            lsu_req_alu_op2_q <= '0;
            cmd_valid_q       <= 1'b0;
            cmd_read_q        <= 1'b0;
            cmd_addr_q        <= '0;
            cmd_wdata_q       <= '0;
            rsp_ready_q       <= 1'b0;
            wbck_valid_q      <= 1'b0;
            wbck_wdat_q       <= '0;
            wbck_rdidx_q      <= '0;
            wbck_err_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            op_q              <= op_d;
            addr_q            <= addr_d;
            rdata_q           <= rdata_d;
            err_q             <= err_d;
            i_ready_q         <= i_ready_d;
            busy_q            <= busy_d;
            lsu_req_alu_q     <= lsu_req_alu_d;
            lsu_req_alu_op1_q <= lsu_req_alu_op1_d;
            lsu_req_alu_op2_q <= lsu_req_alu_op2_d;
            cmd_valid_q       <= cmd_valid_d;
            cmd_read_q        <= cmd_read_d;
            cmd_addr_q        <= cmd_addr_d;
            cmd_wdata_q       <= cmd_wdata_d;
            rsp_ready_q       <= rsp_ready_d;
            wbck_valid_q      <= wbck_valid_d;
            wbck_wdat_q       <= wbck_wdat_d;
            wbck_rdidx_q      <= wbck_rdidx_d;
            wbck_err_q        <= wbck_err_d;
        end
    end

    assign i_ready         = i_ready_q;
    assign busy            = busy_q;
    assign lsu_req_alu     = lsu_req_alu_q;
    assign lsu_req_alu_op1 = lsu_req_alu_op1_q;
    assign lsu_req_alu_op2 = lsu_req_alu_op2_q;
    assign cmd_valid       = cmd_valid_q;
    assign cmd_read        = cmd_read_q;
    assign cmd_addr        = cmd_addr_q;
    assign cmd_wdata       = cmd_wdata_q;
    assign rsp_ready       = rsp_ready_q;
    assign wbck_valid      = wbck_valid_q;
    assign wbck_wdat       = wbck_wdat_q;
    assign wbck_rdidx      = wbck_rdidx_q;
    assign wbck_err        = wbck_err_q;

endmodule

// File: tb/tb_qpu_exu_alu_lsu_agu.sv
// Directed bench for qpu_exu_alu_lsu_agu with a combinational ALU adder stub.
module tb_qpu_exu_alu_lsu_agu;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic        i_load;
    logic [31:0] i_rs1;
    logic [31:0] i_imm;
    logic [31:0] i_wdata;
    logic [4:0]  i_rdidx;
    logic        lsu_req_alu;
    logic [31:0] lsu_req_alu_op1;
    logic [31:0] lsu_req_alu_op2;
    logic [31:0] lsu_req_alu_res;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wbck_valid;
    logic        wbck_ready;
    logic [31:0] wbck_wdat;
    logic [4:0]  wbck_rdidx;
    logic        wbck_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    qpu_exu_alu_lsu_agu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (i_valid),
        .i_ready         (i_ready),
        .i_load          (i_load),
        .i_rs1           (i_rs1),
        .i_imm           (i_imm),
        .i_wdata         (i_wdata),
        .i_rdidx         (i_rdidx),
        .lsu_req_alu     (lsu_req_alu),
        .lsu_req_alu_op1 (lsu_req_alu_op1),
        .lsu_req_alu_op2 (lsu_req_alu_op2),
        .lsu_req_alu_res (lsu_req_alu_res),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_read        (cmd_read),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .wbck_valid      (wbck_valid),
        .wbck_ready      (wbck_ready),
        .wbck_wdat       (wbck_wdat),
        .wbck_rdidx      (wbck_rdidx),
        .wbck_err        (wbck_err),
        .busy            (busy)
    );

    // ALU datapath stand-in: 32-bit wrapping add.
    assign lsu_req_alu_res = lsu_req_alu_op1 + lsu_req_alu_op2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic ld, input logic [31:0] rs1, input logic [31:0] imm,
                         input logic [31:0] wd, input logic [4:0] rd);
        i_valid = 1'b1;
        i_load  = ld;
        i_rs1   = rs1;
        i_imm   = imm;
        i_wdata = wd;
        i_rdidx = rd;
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_load = 1'b0; i_rs1 = '0; i_imm = '0;
        i_wdata = '0; i_rdidx = '0; cmd_ready = 1'b0; rsp_valid = 1'b0;
        rsp_rdata = '0; rsp_err = 1'b0; wbck_ready = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_wbck_valid", 32'(wbck_valid), 32'd0);
        chk("rst_lsu_req", 32'(lsu_req_alu), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_i_ready", 32'(i_ready), 32'd1);

        // Basic load, minimum latency
        offer(1'b1, 32'h0000_1000, 32'h0000_0010, 32'h0, 5'd7);
        cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'hDEAD_BEEF;
        step();
        i_valid = 1'b0;
        chk("ld_lsu_req", 32'(lsu_req_alu), 32'd1);
        chk("ld_op1", lsu_req_alu_op1, 32'h0000_1000);
        chk("ld_op2", lsu_req_alu_op2, 32'h0000_0010);
        chk("ld_busy", 32'(busy), 32'd1);
        chk("ld_i_ready", 32'(i_ready), 32'd0);
        step();
        chk("ld_lsu_req_off", 32'(lsu_req_alu), 32'd0);
        chk("ld_op1_off", lsu_req_alu_op1, 32'd0);
        chk("ld_cmd_valid", 32'(cmd_valid), 32'd1);
        chk("ld_cmd_addr", cmd_addr, 32'h0000_1010);
        chk("ld_cmd_read", 32'(cmd_read), 32'd1);
        chk("ld_cmd_wdata", cmd_wdata, 32'd0);
        step();
        chk("ld_rsp_ready", 32'(rsp_ready), 32'd1);
        chk("ld_cmd_valid_off", 32'(cmd_valid), 32'd0);
        step();
        chk("ld_wbck_valid", 32'(wbck_valid), 32'd1);
        chk("ld_wbck_wdat", wbck_wdat, 32'hDEAD_BEEF);
        chk("ld_wbck_rdidx", 32'(wbck_rdidx), 32'd7);
        chk("ld_wbck_err", 32'(wbck_err), 32'd0);
        chk("ld_rsp_ready_off", 32'(rsp_ready), 32'd0);
        wbck_ready = 1'b1;
        step();
        wbck_ready = 1'b0;
        chk("ld_wbck_done", 32'(wbck_valid), 32'd0);
        chk("ld_back_idle", 32'(i_ready), 32'd1);

        // Store with command backpressure
        offer(1'b0, 32'h0000_2000, 32'hFFFF_FFFC, 32'h0000_0055, 5'd9);
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h1234_5678;
        step();
        i_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("st_cmd_valid", 32'(cmd_valid), 32'd1);
            chk("st_cmd_addr", cmd_addr, 32'h0000_1FFC);
            chk("st_cmd_read", 32'(cmd_read), 32'd0);
            chk("st_cmd_wdata", cmd_wdata, 32'h0000_0055);
            step();
        end
        cmd_ready = 1'b1;
        chk("st_cmd_addr_6", cmd_addr, 32'h0000_1FFC);
        chk("st_cmd_wdata_6", cmd_wdata, 32'h0000_0055);
        step();
        cmd_ready = 1'b0;
        chk("st_rsp_ready", 32'(rsp_ready), 32'd1);
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        chk("st_wbck_valid", 32'(wbck_valid), 32'd1);
        chk("st_wbck_wdat", wbck_wdat, 32'd0);
        chk("st_wbck_rdidx", 32'(wbck_rdidx), 32'd0);
        chk("st_wbck_err", 32'(wbck_err), 32'd0);
        wbck_ready = 1'b1;
        step();
        wbck_ready = 1'b0;

        // Address wrap and bus error
        offer(1'b1, 32'hFFFF_FFF8, 32'h0000_0010, 32'h0, 5'd3);
        cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_err = 1'b1; rsp_rdata = 32'hA5A5_A5A5;
        step();
        i_valid = 1'b0;
        step();
        chk("wr_cmd_addr", cmd_addr, 32'h0000_0008);
        step();
        step();
        chk("wr_wbck_valid", 32'(wbck_valid), 32'd1);
        chk("wr_wbck_err", 32'(wbck_err), 32'd1);
        chk("wr_wbck_wdat", wbck_wdat, 32'hA5A5_A5A5);
        chk("wr_wbck_rdidx", 32'(wbck_rdidx), 32'd3);
        rsp_err = 1'b0;
        wbck_ready = 1'b1;
        step();
        wbck_ready = 1'b0;

        // Write-back stall with dispatch held valid
        offer(1'b1, 32'h0000_3000, 32'h0000_0004, 32'h0, 5'd1);
        rsp_rdata = 32'h0000_00FF;
        step();
        step();
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk("hs_wbck_valid", 32'(wbck_valid), 32'd1);
            chk("hs_i_ready", 32'(i_ready), 32'd0);
            chk("hs_wbck_rdidx", 32'(wbck_rdidx), 32'd1);
            step();
        end
        wbck_ready = 1'b1;
        chk("hs_i_ready_hs", 32'(i_ready), 32'd0);
        step();
        wbck_ready = 1'b0;
        chk("hs_wbck_done", 32'(wbck_valid), 32'd0);
        chk("hs_i_ready_next", 32'(i_ready), 32'd1);
        offer(1'b1, 32'h0000_4000, 32'h0000_0008, 32'h0, 5'd2);
        step();
        i_valid = 1'b0;
        chk("hs2_busy", 32'(busy), 32'd1);
        chk("hs2_op1", lsu_req_alu_op1, 32'h0000_4000);
        step();
        chk("hs2_cmd_addr", cmd_addr, 32'h0000_4008);
        step();
        step();
        chk("hs2_wbck_rdidx", 32'(wbck_rdidx), 32'd2);
        chk("hs2_wbck_wdat", wbck_wdat, 32'h0000_00FF);
        wbck_ready = 1'b1;
        step();
        wbck_ready = 1'b0;

        // Asynchronous reset while waiting for the response
        offer(1'b1, 32'h0000_5000, 32'h0, 32'h0, 5'd5);
        rsp_valid = 1'b0;
        step();
        i_valid = 1'b0;
        step();
        step();
        chk("ar_rsp_ready", 32'(rsp_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rsp_ready_0", 32'(rsp_ready), 32'd0);
        chk("ar_busy_0", 32'(busy), 32'd0);
        chk("ar_i_ready_0", 32'(i_ready), 32'd0);
        chk("ar_cmd_valid_0", 32'(cmd_valid), 32'd0);
        chk("ar_wbck_valid_0", 32'(wbck_valid), 32'd0);
        rsp_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ar_no_wbck", 32'(wbck_valid), 32'd0);
        end
        chk("ar_idle", 32'(i_ready), 32'd1);
        rsp_valid = 1'b0;

        // Misaligned effective address
        offer(1'b1, 32'h0000_1001, 32'h0, 32'h0, 5'd4);
        cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h0BAD_F00D;
        step();
        i_valid = 1'b0;
        step();
`ifdef QPU_LSU_MISALIGN_CHK_EN
        chk("ma_no_cmd", 32'(cmd_valid), 32'd0);
        chk("ma_wbck_valid", 32'(wbck_valid), 32'd1);
        chk("ma_wbck_err", 32'(wbck_err), 32'd1);
        chk("ma_wbck_wdat", wbck_wdat, 32'd0);
`else
        chk("ma_cmd_valid", 32'(cmd_valid), 32'd1);
        chk("ma_cmd_addr", cmd_addr, 32'h0000_1001);
        step();
        step();
        chk("ma_wbck_valid", 32'(wbck_valid), 32'd1);
        chk("ma_wbck_err", 32'(wbck_err), 32'd0);
        chk("ma_wbck_wdat", wbck_wdat, 32'h0BAD_F00D);
`endif
        wbck_ready = 1'b1;
        step();
        wbck_ready = 1'b0;
        chk("ma_done", 32'(wbck_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
